// File: rtl/alarm_clock_pkg.sv
// Shared types and BCD helpers for the multi-channel alarm clock.
// Time words are packed {ms_hr, ls_hr, ms_min, ls_min}, one BCD digit per nibble.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_e;

  localparam int TIME_W     = 16;
  localparam int SEC_W      = 8;
  localparam int DIGIT_W    = 4;
  localparam int LS_MIN_LSB = 0;
  localparam int MS_MIN_LSB = 4;
  localparam int LS_HR_LSB  = 8;
  localparam int MS_HR_LSB  = 12;

  function automatic logic bcd_time_valid(input logic [TIME_W-1:0] t);
    logic [DIGIT_W-1:0] ms_hr;
    logic [DIGIT_W-1:0] ls_hr;
    logic [DIGIT_W-1:0] ms_min;
    logic [DIGIT_W-1:0] ls_min;
    ms_hr  = t[MS_HR_LSB  +: DIGIT_W];
    ls_hr  = t[LS_HR_LSB  +: DIGIT_W];
    ms_min = t[MS_MIN_LSB +: DIGIT_W];
    ls_min = t[LS_MIN_LSB +: DIGIT_W];
    return (ls_min <= 4'd9) && (ms_min <= 4'd5) && (ls_hr <= 4'd9) &&
           ((ms_hr < 4'd2) || ((ms_hr == 4'd2) && (ls_hr <= 4'd3)));
  endfunction

endpackage

// File: rtl/alarm_clock_multi_counter.sv
// Time-of-day keeper: prescaler, BCD seconds/minutes/hours, fastwatch and load.
// The load input must already be validated; a load restarts the second.
module bcd_time_counter
  import alarm_clock_pkg::*;
#(
  parameter int CLK_PER_SEC = 256
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_fastwatch,
  input  logic              i_load,
  input  logic [TIME_W-1:0] i_set_time,
  output logic [TIME_W-1:0] o_current_time,
  output logic [SEC_W-1:0]  o_current_sec,
  output logic              o_one_minute
);

  localparam int PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_SEC - 1);

  logic [PRE_W-1:0]  r_prescaler;
  logic [TIME_W-1:0] r_time;
  logic [SEC_W-1:0]  r_sec;
  logic              r_one_minute;
  logic              w_sec_tick;
  logic              w_sec_wrap;

  function automatic logic [TIME_W-1:0] next_minute(input logic [TIME_W-1:0] t);
    logic [DIGIT_W-1:0] mh;
    logic [DIGIT_W-1:0] lh;
    logic [DIGIT_W-1:0] mm;
    logic [DIGIT_W-1:0] lm;
    mh = t[MS_HR_LSB  +: DIGIT_W];
    lh = t[LS_HR_LSB  +: DIGIT_W];
    mm = t[MS_MIN_LSB +: DIGIT_W];
    lm = t[LS_MIN_LSB +: DIGIT_W];
    if (lm != 4'd9) begin
      lm = lm + 4'd1;
    end else begin
      lm = 4'd0;
      if (mm != 4'd5) begin
        mm = mm + 4'd1;
      end else begin
        mm = 4'd0;
        if ((mh == 4'd2) && (lh == 4'd3)) begin
          mh = 4'd0;
          lh = 4'd0;
        end else if (lh == 4'd9) begin
          lh = 4'd0;
          mh = mh + 4'd1;
        end else begin
          lh = lh + 4'd1;
        end
      end
    end
    return {mh, lh, mm, lm};
  endfunction

  function automatic logic [SEC_W-1:0] next_second(input logic [SEC_W-1:0] s);
    if (s[3:0] == 4'd9) begin
      return {s[7:4] + 4'd1, 4'd0};
    end else begin
      return {s[7:4], s[3:0] + 4'd1};
    end
  endfunction

  assign w_sec_tick = (r_prescaler == PRE_MAX);
  assign w_sec_wrap = (r_sec == 8'h59);

  // Prescaler and BCD time registers; one_minute marks the cycle a new minute is visible
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_prescaler  <= {PRE_W{1'b0}};
      r_time       <= 16'h0000;
      r_sec        <= 8'h00;
      r_one_minute <= 1'b0;
    end else begin
      r_one_minute <= 1'b0;
      if (i_load) begin
        r_time      <= i_set_time;
        r_sec       <= 8'h00;
        r_prescaler <= {PRE_W{1'b0}};
      end else if (w_sec_tick) begin
        r_prescaler <= {PRE_W{1'b0}};
        if (i_fastwatch || w_sec_wrap) begin
          r_sec        <= 8'h00;
          r_time       <= next_minute(r_time);
          r_one_minute <= 1'b1;
        end else begin
          r_sec <= next_second(r_sec);
        end
      end else begin
        r_prescaler <= r_prescaler + PRE_W'(1);
      end
    end
  end

  assign o_current_time = r_time;
  assign o_current_sec  = r_sec;
  assign o_one_minute   = r_one_minute;

endmodule

// File: rtl/alarm_clock_multi.sv
// Alarm clock core: alarm register file, lowest-index match selection and the
// IDLE/RING/SNOOZE controller around the BCD time counter.
module alarm_clock_multi
  import alarm_clock_pkg::*;
#(
  parameter int CLK_PER_SEC      = 256,
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_fastwatch,
  input  logic                  i_load_time,
  input  logic [TIME_W-1:0]     i_set_time,
  input  logic                  i_alarm_wr,
  input  logic [SEL_W-1:0]      i_alarm_sel,
  input  logic [TIME_W-1:0]     i_alarm_time,
  input  logic                  i_alarm_en,
  input  logic                  i_snooze,
  input  logic                  i_stop,
  output logic [TIME_W-1:0]     o_current_time,
  output logic [SEC_W-1:0]      o_current_sec,
  output logic                  o_one_minute,
  output logic                  o_alarm_sound,
  output logic [SEL_W-1:0]      o_ring_id,
  output logic [NUM_ALARMS-1:0] o_alarm_enabled,
  output logic                  o_load_err
);

  localparam logic [3:0] SNOOZE_INIT = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LAST   = 4'(RING_TIMEOUT_MIN - 1);

  logic [TIME_W-1:0]     r_alarm_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_alarm_en;
  logic                  r_load_err;
  alarm_state_e          r_state;
  logic                  r_alarm_sound;
  logic [SEL_W-1:0]      r_ring_id;
  logic [3:0]            r_ring_min;
  logic [3:0]            r_snz_min;

  logic                  w_load_accept;
  logic                  w_alarm_accept;
  logic                  w_sel_ok;
  logic [TIME_W-1:0]     w_time;
  logic                  w_one_minute;
  logic [NUM_ALARMS-1:0] w_hit;
  logic                  w_match;
  logic [SEL_W-1:0]      w_winner;

  assign w_sel_ok       = ({1'b0, i_alarm_sel} < (SEL_W + 1)'(NUM_ALARMS));
  assign w_load_accept  = i_load_time & bcd_time_valid(i_set_time);
  assign w_alarm_accept = i_alarm_wr & bcd_time_valid(i_alarm_time) & w_sel_ok;

  bcd_time_counter #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_counter (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_fastwatch   (i_fastwatch),
    .i_load        (w_load_accept),
    .i_set_time    (i_set_time),
    .o_current_time(w_time),
    .o_current_sec (o_current_sec),
    .o_one_minute  (w_one_minute)
  );

  // Alarm register file and rejected-load flag
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_alarm_time[i] <= 16'h0000;
      end
      r_alarm_en <= {NUM_ALARMS{1'b0}};
      r_load_err <= 1'b0;
    end else begin
      if (w_alarm_accept) begin
        r_alarm_time[i_alarm_sel] <= i_alarm_time;
        r_alarm_en[i_alarm_sel]   <= i_alarm_en;
      end else begin
        r_alarm_en <= r_alarm_en;
      end
      r_load_err <= (i_load_time & ~w_load_accept) | (i_alarm_wr & ~w_alarm_accept);
    end
  end

  // Per-channel hits against the freshly registered minute; lowest index wins
  always_comb begin
    w_hit    = {NUM_ALARMS{1'b0}};
    w_winner = {SEL_W{1'b0}};
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_hit[i] = r_alarm_en[i] & (r_alarm_time[i] == w_time);
    end
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      w_winner = w_hit[i] ? SEL_W'(i) : w_winner;
    end
  end

  assign w_match = |w_hit;

  // Ring controller: stop beats snooze beats minute-driven transitions
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_alarm_sound <= 1'b0;
      r_ring_id     <= {SEL_W{1'b0}};
      r_ring_min    <= 4'd0;
      r_snz_min     <= 4'd0;
    end else if (i_stop) begin
      r_state       <= ST_IDLE;
      r_alarm_sound <= 1'b0;
    end else if (i_snooze && (r_state == ST_RING)) begin
      r_state       <= ST_SNOOZE;
      r_alarm_sound <= 1'b0;
      r_snz_min     <= SNOOZE_INIT;
    end else if (w_one_minute) begin
      case (r_state)
        ST_IDLE: begin
          if (w_match) begin
            r_state       <= ST_RING;
            r_alarm_sound <= 1'b1;
            r_ring_id     <= w_winner;
            r_ring_min    <= 4'd0;
          end else begin
            r_alarm_sound <= 1'b0;
          end
        end
        ST_RING: begin
          if (r_ring_min == RING_LAST) begin
            r_state       <= ST_IDLE;
            r_alarm_sound <= 1'b0;
          end else begin
            r_ring_min <= r_ring_min + 4'd1;
          end
        end
        ST_SNOOZE: begin
          if (r_snz_min == 4'd1) begin
            r_state       <= ST_RING;
            r_alarm_sound <= 1'b1;
            r_ring_min    <= 4'd0;
          end else begin
            r_snz_min <= r_snz_min - 4'd1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_alarm_sound <= 1'b0;
        end
      endcase
    end else begin
      r_alarm_sound <= (r_state == ST_RING);
    end
  end

  assign o_current_time  = w_time;
  assign o_one_minute    = w_one_minute;
  assign o_alarm_sound   = r_alarm_sound;
  assign o_ring_id       = r_ring_id;
  assign o_alarm_enabled = r_alarm_en;
  assign o_load_err      = r_load_err;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed and randomized bench for alarm_clock_multi against a minute-count
// reference model of the clock and alarm behaviour.
module tb_alarm_clock_multi;

  localparam int CPS  = 4;
  localparam int NA   = 4;
  localparam int SNZ  = 2;
  localparam int TOUT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fast = 1'b0, ld = 1'b0, wr = 1'b0, aen = 1'b0, snz = 1'b0, stp = 1'b0;
  logic [15:0] st = 16'h0000, at = 16'h0000;
  logic [1:0]  sel = 2'd0;
  logic [15:0] o_time;
  logic [7:0]  o_sec;
  logic        o_one, o_sound, o_err;
  logic [1:0]  o_id;
  logic [3:0]  o_en;

  int checks = 0;
  int errors = 0;

  // reference model state: minutes of day, seconds, ring mode by name
  int m_min, m_sec, m_presc, m_id, m_left;
  bit m_one, m_err;
  int m_al_min [NA];
  bit m_al_en  [NA];
  int m_mode;
  localparam int IDLE_M = 0, RINGING = 1, SNOOZING = 2;

  alarm_clock_multi #(
    .CLK_PER_SEC(CPS), .NUM_ALARMS(NA), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_MIN(TOUT)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_fastwatch(fast), .i_load_time(ld),
    .i_set_time(st), .i_alarm_wr(wr), .i_alarm_sel(sel), .i_alarm_time(at),
    .i_alarm_en(aen), .i_snooze(snz), .i_stop(stp), .o_current_time(o_time),
    .o_current_sec(o_sec), .o_one_minute(o_one), .o_alarm_sound(o_sound),
    .o_ring_id(o_id), .o_alarm_enabled(o_en), .o_load_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic bit tvalid(input logic [15:0] t);
    int d3 = int'(t[15:12]);
    int d2 = int'(t[11:8]);
    int d1 = int'(t[7:4]);
    int d0 = int'(t[3:0]);
    return (d3 <= 9) && (d2 <= 9) && (d1 <= 9) && (d0 <= 9) &&
           (d3 * 10 + d2 < 24) && (d1 * 10 + d0 < 60);
  endfunction

  function automatic int bcd2min(input logic [15:0] t);
    return (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic logic [15:0] min2bcd(input int m);
    int hh = m / 60;
    int mm = m % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  function automatic void model_reset();
    m_min = 0; m_sec = 0; m_presc = 0; m_id = 0; m_left = 0;
    m_one = 1'b0; m_err = 1'b0; m_mode = IDLE_M;
    for (int i = 0; i < NA; i++) begin
      m_al_min[i] = 0;
      m_al_en[i]  = 1'b0;
    end
  endfunction

  function automatic void model_step();
    int found = -1;
    // ring behaviour reacts to the minute pulse visible before this edge
    if (stp) begin
      m_mode = IDLE_M;
    end else if (snz && m_mode == RINGING) begin
      m_mode = SNOOZING;
      m_left = SNZ;
    end else if (m_one) begin
      if (m_mode == IDLE_M) begin
        for (int i = 0; i < NA; i++)
          if (found < 0 && m_al_en[i] && m_al_min[i] == m_min) found = i;
        if (found >= 0) begin
          m_mode = RINGING; m_id = found; m_left = TOUT;
        end
      end else if (m_mode == RINGING) begin
        m_left--;
        if (m_left == 0) m_mode = IDLE_M;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_mode = RINGING; m_left = TOUT;
        end
      end
    end
    m_err = 1'b0;
    m_one = 1'b0;
    if (wr) begin
      if (tvalid(at) && int'(sel) < NA) begin
        m_al_min[sel] = bcd2min(at);
        m_al_en[sel]  = aen;
      end else m_err = 1'b1;
    end
    if (ld && tvalid(st)) begin
      m_min = bcd2min(st); m_sec = 0; m_presc = 0;
    end else begin
      if (ld) m_err = 1'b1;
      if (m_presc == CPS - 1) begin
        m_presc = 0;
        if (fast || m_sec == 59) begin
          m_sec = 0; m_min = (m_min + 1) % 1440; m_one = 1'b1;
        end else m_sec++;
      end else m_presc++;
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] en_exp;
    for (int i = 0; i < NA; i++) en_exp[i] = m_al_en[i];
    chk("time", o_time, min2bcd(m_min));
    chk("sec", {8'h00, o_sec}, {8'h00, 4'(m_sec / 10), 4'(m_sec % 10)});
    chk("one_minute", {15'd0, o_one}, {15'd0, m_one});
    chk("sound", {15'd0, o_sound}, {15'd0, (m_mode == RINGING)});
    chk("ring_id", {14'd0, o_id}, 16'(m_id));
    chk("enabled", {12'd0, o_en}, {12'd0, en_exp});
    chk("load_err", {15'd0, o_err}, {15'd0, m_err});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic pulse_load(input logic [15:0] t);
    ld = 1'b1; st = t;
    tick();
    ld = 1'b0;
  endtask

  task automatic write_alarm(input logic [1:0] s, input logic [15:0] t, input logic e);
    wr = 1'b1; sel = s; at = t; aen = e;
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_minute();
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = o_one;
    end
    chk("minute_seen", {15'd0, seen}, 16'd1);
  endtask

  initial begin
    int ones;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_all();
    chk("reset_time", o_time, 16'h0000);
    @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // 23:59 rolls to 00:00 after one full minute of seconds
    pulse_load(16'h2359);
    chk("loaded", o_time, 16'h2359);
    ones = 0;
    repeat (240) begin
      tick();
      ones += int'(o_one);
    end
    chk("wrap_time", o_time, 16'h0000);
    chk("wrap_sec", {8'h00, o_sec}, 16'h0000);
    chk("wrap_pulses", 16'(ones), 16'd1);

    // rejected loads
    pulse_load(16'h2460);
    chk("bad_load_err", {15'd0, o_err}, 16'd1);
    chk("bad_load_time", o_time, 16'h0000);
    write_alarm(2'd1, 16'h0961, 1'b1);
    chk("bad_wr_err", {15'd0, o_err}, 16'd1);
    chk("bad_wr_en", {12'd0, o_en}, 16'h0000);

    // two channels match; lowest index wins
    write_alarm(2'd2, 16'h0700, 1'b1);
    write_alarm(2'd0, 16'h0700, 1'b1);
    fast = 1'b1;
    pulse_load(16'h0659);
    wait_minute();
    chk("match_time", o_time, 16'h0700);
    chk("sound_lag", {15'd0, o_sound}, 16'd0);
    tick();
    chk("ring_start", {15'd0, o_sound}, 16'd1);
    chk("ring_id0", {14'd0, o_id}, 16'd0);

    // snooze then re-ring after two minutes
    snz = 1'b1; tick(); snz = 1'b0;
    chk("snoozed", {15'd0, o_sound}, 16'd0);
    wait_minute(); tick();
    chk("snooze_mid", {15'd0, o_sound}, 16'd0);
    wait_minute(); tick();
    chk("re_ring", {15'd0, o_sound}, 16'd1);
    chk("re_ring_id", {14'd0, o_id}, 16'd0);

    // auto timeout on the third minute
    wait_minute(); tick();
    chk("tout1", {15'd0, o_sound}, 16'd1);
    wait_minute(); tick();
    chk("tout2", {15'd0, o_sound}, 16'd1);
    wait_minute(); tick();
    chk("tout3", {15'd0, o_sound}, 16'd0);

    // stop beats snooze
    pulse_load(16'h0659);
    wait_minute(); tick();
    chk("ring_again", {15'd0, o_sound}, 16'd1);
    stp = 1'b1; snz = 1'b1; tick(); stp = 1'b0; snz = 1'b0;
    chk("stop_snooze", {15'd0, o_sound}, 16'd0);
    wait_minute(); tick();
    chk("stays_idle", {15'd0, o_sound}, 16'd0);

    // asynchronous reset while ringing
    pulse_load(16'h0659);
    wait_minute(); tick();
    chk("ring_pre_rst", {15'd0, o_sound}, 16'd1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_sound", {15'd0, o_sound}, 16'd0);
    chk("rst_time", o_time, 16'h0000);
    chk("rst_en", {12'd0, o_en}, 16'h0000);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // randomized traffic
    fast = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      ld  = ($urandom_range(0, 63) == 0);
      st  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : min2bcd($urandom_range(0, 1439));
      wr  = ($urandom_range(0, 15) == 0);
      sel = 2'($urandom_range(0, 3));
      at  = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                       : min2bcd((m_min + $urandom_range(0, 3)) % 1440);
      aen = ($urandom_range(0, 3) != 0);
      snz = ($urandom_range(0, 19) == 0);
      stp = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) fast = ~fast;
      tick();
    end
    ld = 1'b0; wr = 1'b0; snz = 1'b0; stp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
